mem_arbiter: RTL and testbench

Arbitrates the single unified-memory port between the I-cache fill path and the D-cache read/write/evict path. It latches one request at a time and holds `u_re`/`u_we`, the address and the write data stable until memory returns `u_rdy`. It then returns a one-cycle acknowledge with the line data to the winning requester. The block sits between the cache controllers and the unified memory model, and alternates the grant when both sides contend.

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the cache-side request/ack signals and the unified-memory port.
// slave: the arbiter's view. master: the cache controllers plus memory model.
interface mem_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int LINE_W = 64
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [LINE_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic              d_ack;
    logic [LINE_W-1:0] d_rdata;
    logic              u_re;
    logic              u_we;
    logic [ADDR_W-1:0] u_addr;
    logic [LINE_W-1:0] u_wdata;
    logic [LINE_W-1:0] u_rdata;
    logic              u_rdy;
    logic              err;
    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, u_rdata, u_rdy,
        output i_ack, i_rdata, d_ack, d_rdata, u_re, u_we, u_addr, u_wdata,
               err, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, u_rdata, u_rdy,
        input  i_ack, i_rdata, d_ack, d_rdata, u_re, u_we, u_addr, u_wdata,
               err, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Unified-memory arbiter between the I-cache fill path and the D-cache path.
// One transaction in flight; D and I alternate when both request together.
//
// state | meaning
// IDLE  | sample i_req/d_req, grant one and latch its command
// BUSY  | strobe held to memory until u_rdy or the timeout count expires
// RESP  | one-cycle ack to the owner, err if the transaction timed out
module mem_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int LINE_W  = 64,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nx;
    logic              gnt_d;
    logic              wr;
    logic              last_d;
    logic              to_q;
    logic [7:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] i_rdata_q;
    logic [LINE_W-1:0] d_rdata_q;

    logic              grant;
    logic              grant_d;
    logic              done;
    logic              timeout;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and per-cycle control; u_rdy beats the timeout on the same edge.
    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        grant_d  = 1'b0;
        done     = 1'b0;
        timeout  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    grant    = 1'b1;
                    grant_d  = bus.d_req && (!bus.i_req || !last_d);
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (bus.u_rdy) begin
                    done     = 1'b1;
                    state_nx = RESP;
                end else if (cnt == CNT_LAST) begin
                    timeout  = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Command latch, timeout counter and per-side read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_d     <= 1'b0;
            wr        <= 1'b0;
            last_d    <= 1'b0;
            to_q      <= 1'b0;
            cnt       <= 8'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (grant) begin
                gnt_d  <= grant_d;
                wr     <= grant_d && bus.d_we;
                addr_q <= grant_d ? bus.d_addr : bus.i_addr;
                if (grant_d) wdata_q <= bus.d_wdata;
                cnt    <= 8'd0;
                last_d <= grant_d;
                to_q   <= 1'b0;
            end
            if (state == BUSY && !done && !timeout) cnt <= cnt + 8'd1;
            if (done || timeout) begin
                to_q <= timeout;
                // A timed-out read returns a zero line rather than stale data.
                if (!wr) begin
                    if (gnt_d) d_rdata_q <= done ? bus.u_rdata : '0;
                    else       i_rdata_q <= done ? bus.u_rdata : '0;
                end
            end
        end
    end

    assign bus.u_re    = (state == BUSY) && !wr;
    assign bus.u_we    = (state == BUSY) && wr;
    assign bus.u_addr  = addr_q;
    assign bus.u_wdata = wdata_q;
    assign bus.i_ack   = (state == RESP) && !gnt_d;
    assign bus.d_ack   = (state == RESP) && gnt_d;
    assign bus.err     = (state == RESP) && to_q;
    assign bus.busy    = (state == BUSY) || (state == RESP);
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, I read, D write, contention,
// single requester, timeout, u_rdy/timeout tie and reset mid-BUSY.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(14), .LINE_W(64)) bus ();

    mem_arbiter #(.ADDR_W(14), .LINE_W(64), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ure"},  64'(bus.u_re),  64'd0);
        chk({tag, "_uwe"},  64'(bus.u_we),  64'd0);
        chk({tag, "_iack"}, 64'(bus.i_ack), 64'd0);
        chk({tag, "_dack"}, 64'(bus.d_ack), 64'd0);
        chk({tag, "_err"},  64'(bus.err),   64'd0);
        chk({tag, "_busy"}, 64'(bus.busy),  64'd0);
    endtask

    initial begin
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.u_rdata = '0;
        bus.u_rdy   = 1'b0;

        // Reset values
        step(); step();
        chk_idle("rst");
        chk("rst_irdata", bus.i_rdata, 64'd0);
        chk("rst_drdata", bus.d_rdata, 64'd0);
        chk("rst_uaddr",  64'(bus.u_addr), 64'd0);
        chk("rst_uwdata", bus.u_wdata, 64'd0);
        rst = 1'b0;
        step();

        // I read, memory answers in the 4th BUSY cycle
        bus.i_req  = 1'b1;
        bus.i_addr = 14'h0123;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("ird_ure",   64'(bus.u_re),   64'd1);
            chk("ird_uaddr", 64'(bus.u_addr), 64'h0123);
            chk("ird_iack",  64'(bus.i_ack),  64'd0);
            if (k == 3) begin
                bus.u_rdy   = 1'b1;
                bus.u_rdata = 64'hDEADBEEF_CAFEF00D;
            end
            step();
        end
        chk("ird_resp_ure", 64'(bus.u_re),  64'd0);
        chk("ird_iack1",    64'(bus.i_ack), 64'd1);
        chk("ird_dack",     64'(bus.d_ack), 64'd0);
        chk("ird_err",      64'(bus.err),   64'd0);
        chk("ird_rdata",    bus.i_rdata,    64'hDEADBEEF_CAFEF00D);
        bus.i_req = 1'b0;
        bus.u_rdy = 1'b0;
        step();
        chk_idle("ird_end");
        chk("ird_hold", bus.i_rdata, 64'hDEADBEEF_CAFEF00D);

        // D write; memory drives junk read data that must not be captured
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 14'h3FFF;
        bus.d_wdata = 64'h1111_2222_3333_4444;
        bus.u_rdata = 64'h9999_8888_7777_6666;
        step();
        for (int k = 0; k < 2; k++) begin
            chk("dwr_uwe",   64'(bus.u_we),   64'd1);
            chk("dwr_ure",   64'(bus.u_re),   64'd0);
            chk("dwr_uaddr", 64'(bus.u_addr), 64'h3FFF);
            chk("dwr_uwd",   bus.u_wdata,     64'h1111_2222_3333_4444);
            if (k == 1) bus.u_rdy = 1'b1;
            step();
        end
        chk("dwr_dack",  64'(bus.d_ack), 64'd1);
        chk("dwr_iack",  64'(bus.i_ack), 64'd0);
        chk("dwr_uwe0",  64'(bus.u_we),  64'd0);
        chk("dwr_rdata", bus.d_rdata,    64'd0);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        bus.u_rdy = 1'b0;
        step();
        chk_idle("dwr_end");

        // Contention after reset: D, I, D, I
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.i_addr = 14'h0A0A;
        bus.d_addr = 14'h0B0B;
        bus.i_req  = 1'b1;
        bus.d_req  = 1'b1;
        for (int r = 0; r < 4; r++) begin
            step();
            chk("cnt_busy", 64'(bus.busy), 64'd1);
            chk("cnt_uaddr", 64'(bus.u_addr), (r % 2 == 0) ? 64'h0B0B : 64'h0A0A);
            bus.u_rdy   = 1'b1;
            bus.u_rdata = 64'hA0 + 64'(r);
            step();
            chk("cnt_dack", 64'(bus.d_ack), (r % 2 == 0) ? 64'd1 : 64'd0);
            chk("cnt_iack", 64'(bus.i_ack), (r % 2 == 0) ? 64'd0 : 64'd1);
            if (r % 2 == 0) begin
                chk("cnt_drdata", bus.d_rdata, 64'hA0 + 64'(r));
                bus.d_req = 1'b0;
            end else begin
                chk("cnt_irdata", bus.i_rdata, 64'hA0 + 64'(r));
                bus.i_req = 1'b0;
            end
            bus.u_rdy = 1'b0;
            step();
            chk("cnt_idle", 64'(bus.busy), 64'd0);
            bus.i_req = 1'b1;
            bus.d_req = 1'b1;
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        step();

        // Single requester: I granted every time
        for (int r = 0; r < 3; r++) begin
            bus.i_req  = 1'b1;
            bus.i_addr = 14'h0100 + 14'(r);
            step();
            chk("sgl_uaddr", 64'(bus.u_addr), 64'h0100 + 64'(r));
            bus.u_rdy   = 1'b1;
            bus.u_rdata = 64'hC0 + 64'(r);
            step();
            chk("sgl_iack", 64'(bus.i_ack), 64'd1);
            chk("sgl_dack", 64'(bus.d_ack), 64'd0);
            bus.i_req = 1'b0;
            bus.u_rdy = 1'b0;
            step();
        end

        // Timeout: D read, u_rdy never comes
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 14'h0042;
        step();
        for (int k = 0; k < 15; k++) begin
            chk("to_ure",  64'(bus.u_re),  64'd1);
            chk("to_dack", 64'(bus.d_ack), 64'd0);
            step();
        end
        chk("to_dack1", 64'(bus.d_ack), 64'd1);
        chk("to_err1",  64'(bus.err),   64'd1);
        chk("to_ure0",  64'(bus.u_re),  64'd0);
        chk("to_rdata", bus.d_rdata,    64'd0);
        bus.d_req = 1'b0;
        step();
        chk_idle("to_end");

        // u_rdy on the 15th BUSY cycle wins over the timeout
        bus.d_req  = 1'b1;
        bus.d_addr = 14'h0043;
        step();
        for (int k = 0; k < 15; k++) begin
            chk("tie_ure", 64'(bus.u_re), 64'd1);
            if (k == 14) begin
                bus.u_rdy   = 1'b1;
                bus.u_rdata = 64'h5555_AAAA_5555_AAAA;
            end
            step();
        end
        chk("tie_dack",  64'(bus.d_ack), 64'd1);
        chk("tie_err",   64'(bus.err),   64'd0);
        chk("tie_rdata", bus.d_rdata,    64'h5555_AAAA_5555_AAAA);
        bus.d_req = 1'b0;
        bus.u_rdy = 1'b0;
        step();

        // Reset in the 2nd BUSY cycle of a D read
        bus.d_req  = 1'b1;
        bus.d_addr = 14'h0777;
        step();
        chk("mid_ure", 64'(bus.u_re), 64'd1);
        step();
        rst = 1'b1;
        step();
        chk_idle("mid_rst");
        chk("mid_drdata", bus.d_rdata, 64'd0);
        rst = 1'b0;
        bus.d_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mid_noack", 64'({bus.i_ack, bus.d_ack, bus.err}), 64'd0);
        end
        // Fresh tie: D must win again, then the held I request completes
        bus.i_req  = 1'b1;
        bus.i_addr = 14'h0321;
        bus.d_req  = 1'b1;
        bus.d_addr = 14'h0654;
        step();
        bus.u_rdy   = 1'b1;
        bus.u_rdata = 64'h0D0D;
        step();
        chk("post_dack", 64'(bus.d_ack), 64'd1);
        chk("post_iack", 64'(bus.i_ack), 64'd0);
        bus.d_req = 1'b0;
        bus.u_rdy = 1'b0;
        step();
        step();
        chk("post_iaddr", 64'(bus.u_addr), 64'h0321);
        bus.u_rdy   = 1'b1;
        bus.u_rdata = 64'h1E1E;
        step();
        chk("post_iack2", 64'(bus.i_ack), 64'd1);
        chk("post_irdat", bus.i_rdata,    64'h1E1E);
        bus.i_req = 1'b0;
        bus.u_rdy = 1'b0;
        step();
        chk_idle("post_end");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
